// File: rtl/bitfusion_pkg.sv
// Shared Bit Fusion types and constants: lane bitwidth encodings and chunks per 32-bit word.
package bitfusion_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [2:0] bitwidth_t;

  localparam bitwidth_t BW_2B = 3'b001;
  localparam bitwidth_t BW_4B = 3'b010;
  localparam bitwidth_t BW_8B = 3'b100;

  localparam int unsigned CHUNKS_8B = 4;
  localparam int unsigned CHUNKS_4B = 2;
  localparam int unsigned CHUNKS_2B = 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Chunk index that completes a word for the given width; 0 for illegal encodings.
  function automatic logic [1:0] last_idx(input bitwidth_t bw);
    case (bw)
      BW_8B:   last_idx = 2'(CHUNKS_8B - 1);
      BW_4B:   last_idx = 2'(CHUNKS_4B - 1);
      BW_2B:   last_idx = 2'(CHUNKS_2B - 1);
      default: last_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/w_pack_if.sv
// Lane-side input handshake plus buffer-side output handshake of the weight/result packer.
interface w_pack_if;
  import bitfusion_pkg::*;

  bitwidth_t           input_bitwidth;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   data_in;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   data_out;

  modport master (
    output input_bitwidth, in_valid, data_in, flush, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  input_bitwidth, in_valid, data_in, flush, out_ready,
    output in_ready, out_valid, data_out
  );

endinterface

// File: rtl/w_pack.sv
// Gathers 8/16/32-bit chunks into one 32-bit word per group and emits it through
// a single-entry output register with valid/ready backpressure and partial-word flush.
module w_pack
  import bitfusion_pkg::*;
(
  input  logic     clk,
  input  logic     RST,
  w_pack_if.slave  bus
);

  logic [DATA_W-1:0] asm_reg;
  logic [1:0]        wr_ptr;
  bitwidth_t         bw_lat;
  logic [DATA_W-1:0] data_q;
  out_state_t        state_q;
  out_state_t        state_d;

  logic              in_ready;
  logic              accept;
  logic              take;
  bitwidth_t         bw_use;
  logic [DATA_W-1:0] merged;
  logic              legal;
  logic              complete;
  logic              chunk_ok;
  logic [1:0]        ptr_after;
  logic              flush_fire;
  logic              load;
  logic [DATA_W-1:0] load_word;

  // Input side stalls only while a word is parked and not being taken.
  assign in_ready = (state_q != OUT_FULL) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign take     = (state_q == OUT_FULL) && bus.out_ready;
  assign bw_use   = (wr_ptr == 2'd0) ? bus.input_bitwidth : bw_lat;

  // Lane placement: drop the incoming chunk into the assembly word at wr_ptr.
  always_comb begin
    merged   = asm_reg;
    legal    = 1'b0;
    complete = 1'b0;
    case (bw_use)
      BW_8B: begin
        legal    = 1'b1;
        merged[{wr_ptr, 3'b000} +: 8] = bus.data_in[7:0];
        complete = (wr_ptr == last_idx(BW_8B));
      end
      BW_4B: begin
        legal    = 1'b1;
        merged[{wr_ptr[0], 4'b0000} +: 16] = bus.data_in[15:0];
        complete = (wr_ptr == last_idx(BW_4B));
      end
      BW_2B: begin
        legal    = 1'b1;
        merged   = bus.data_in;
        complete = 1'b1;
      end
      default: begin
        legal    = 1'b0;
        merged   = asm_reg;
        complete = 1'b0;
      end
    endcase
  end

  // Output register FSM plus word-load decision; a completing chunk makes flush redundant.
  always_comb begin
    state_d    = state_q;
    chunk_ok   = accept && legal;
    ptr_after  = wr_ptr;
    flush_fire = 1'b0;
    load       = 1'b0;
    load_word  = asm_reg;

    if (chunk_ok) begin
      ptr_after = complete ? 2'd0 : (wr_ptr + 2'd1);
      load_word = merged;
    end

    flush_fire = in_ready && bus.flush && (ptr_after != 2'd0);
    load       = (chunk_ok && complete) || flush_fire;

    case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL:  if (take && !load) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      asm_reg <= '0;
      wr_ptr  <= 2'd0;
      bw_lat  <= BW_8B;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q  <= load_word;
        asm_reg <= '0;
        wr_ptr  <= 2'd0;
      end else begin
        if (chunk_ok) asm_reg <= merged;
        wr_ptr <= ptr_after;
      end
      if (chunk_ok && (wr_ptr == 2'd0)) bw_lat <= bus.input_bitwidth;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT_FULL);
  assign bus.data_out  = data_q;

endmodule
